// File: rtl/mccp_loader_pkg.sv
// Shared types and constants for the MCCP program loader.
// Control register map matches the videocard_top control slave.
package mccp_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    KICK,
    POLL_REQ,
    POLL_WAIT,
    DONE
  } state_e;

  localparam logic CTRL_START_ADDR  = 1'b0;
  localparam logic CTRL_STATUS_ADDR = 1'b1;
  localparam int   CTRL_START_VAL   = 1;
  localparam int   PROG_BASE        = 65536;

  // Bits needed to hold 0..max_val; at least one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mccp_program_loader_if.sv
// Bundle of the loader's command, stream, videocard and status signals.
// Handshakes: a command or stream word transfers on a rising edge where valid && ready; valid holds its payload until then.
interface mccp_program_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 17
) ();

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [ADDR_W-1:0]        cmd_len;
  logic                     cmd_kick;

  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH-1:0]         s_data;

  logic [ADDR_W-1:0]        address;
  logic [WIDTH-1:0]         data_in;
  logic                     write;

  logic                     address_control;
  logic [WIDTH-1:0]         data_in_control;
  logic                     write_control;
  logic                     read_control;
  logic [WIDTH-1:0]         data_out_control;

  logic                     busy;
  logic                     done;
  logic                     error;
  mccp_loader_pkg::state_e  dbg_state;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_kick,
    input  s_valid, s_data,
    input  data_out_control,
    output cmd_ready, s_ready,
    output address, data_in, write,
    output address_control, data_in_control, write_control, read_control,
    output busy, done, error, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_kick,
    output s_valid, s_data,
    output data_out_control,
    input  cmd_ready, s_ready,
    input  address, data_in, write,
    input  address_control, data_in_control, write_control, read_control,
    input  busy, done, error, dbg_state
  );

endinterface

// File: rtl/mccp_poll_timer.sv
// Loadable saturating down-counter; expire is high while the count is zero.
// Used both for read-latency/poll-gap waits and for the remaining-poll budget.
module mccp_poll_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/mccp_program_loader.sv
// Streams host words into videocard memory, optionally kicks the MCCP and polls for done.
// Optional checksum output: define MCCP_LOADER_CHECKSUM_EN.
module mccp_program_loader
  import mccp_loader_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 8,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 clk,
  input  logic                 reset_sink_reset,
  mccp_program_loader_if.master bus
`ifdef MCCP_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum
`endif
);

  localparam int WAIT_MAX = (READ_LATENCY > POLL_GAP) ? READ_LATENCY : POLL_GAP;
  localparam int WAIT_W   = cnt_width(WAIT_MAX);
  localparam int POLL_W   = cnt_width(TIMEOUT);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  remain_q, remain_d;
  logic               kick_q, kick_d;
  logic               gap_q, gap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [WIDTH-1:0]   data_in_q, data_in_d;
  logic               write_control_q, write_control_d;
  logic               read_control_q, read_control_d;
  logic               address_control_q, address_control_d;
  logic [WIDTH-1:0]   data_in_control_q, data_in_control_d;
`ifdef MCCP_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]   sum_q, sum_d;
`endif

  logic               wait_load, wait_dec, wait_expire;
  logic [WAIT_W-1:0]  wait_val;
  logic               poll_load, poll_dec, poll_expire;
  logic               unused_status;

  mccp_poll_timer #(.W(WAIT_W)) u_wait_timer (
    .clk      (clk),
    .rst      (reset_sink_reset),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .expire   (wait_expire)
  );

  mccp_poll_timer #(.W(POLL_W)) u_poll_budget (
    .clk      (clk),
    .rst      (reset_sink_reset),
    .load     (poll_load),
    .load_val (POLL_W'(TIMEOUT)),
    .dec      (poll_dec),
    .expire   (poll_expire)
  );

  // All bus strobes are registered: an action decided in one state appears on the
  // bus during the following cycle, so the last data write and the kick never overlap.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    remain_d          = remain_q;
    kick_d            = kick_q;
    gap_d             = gap_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    error_d           = error_q;
    write_d           = 1'b0;
    address_d         = address_q;
    data_in_d         = data_in_q;
    write_control_d   = 1'b0;
    read_control_d    = 1'b0;
    address_control_d = address_control_q;
    data_in_control_d = data_in_control_q;
    wait_load         = 1'b0;
    wait_val          = '0;
    wait_dec          = 1'b0;
    poll_load         = 1'b0;
    poll_dec          = 1'b0;
`ifdef MCCP_LOADER_CHECKSUM_EN
    sum_d             = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          remain_d = bus.cmd_len;
          kick_d   = bus.cmd_kick;
          error_d  = 1'b0;
          busy_d   = 1'b1;
`ifdef MCCP_LOADER_CHECKSUM_EN
          sum_d    = '0;
`endif
          if (bus.cmd_len == '0) begin
            state_d = bus.cmd_kick ? KICK : DONE;
          end else begin
            state_d = STREAM;
          end
        end
      end

      STREAM: begin
        if (bus.s_valid) begin
          write_d   = 1'b1;
          address_d = addr_q;
          data_in_d = bus.s_data;
          addr_d    = addr_q + ADDR_W'(1);
          remain_d  = remain_q - ADDR_W'(1);
`ifdef MCCP_LOADER_CHECKSUM_EN
          sum_d     = sum_q + bus.s_data;
`endif
          if (remain_q == ADDR_W'(1)) begin
            state_d = kick_q ? KICK : DONE;
          end
        end
      end

      KICK: begin
        write_control_d   = 1'b1;
        address_control_d = CTRL_START_ADDR;
        data_in_control_d = WIDTH'(CTRL_START_VAL);
        poll_load         = 1'b1;
        state_d           = POLL_REQ;
      end

      POLL_REQ: begin
        read_control_d    = 1'b1;
        address_control_d = CTRL_STATUS_ADDR;
        poll_dec          = 1'b1;
        wait_load         = 1'b1;
        wait_val          = WAIT_W'(READ_LATENCY);
        gap_d             = 1'b0;
        state_d           = POLL_WAIT;
      end

      // gap_q splits this state into the read-latency wait and the inter-poll gap.
      POLL_WAIT: begin
        if (!wait_expire) begin
          wait_dec = 1'b1;
        end else if (gap_q) begin
          state_d = POLL_REQ;
        end else if (bus.data_out_control[0]) begin
          state_d = DONE;
        end else if (poll_expire) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          gap_d     = 1'b1;
          wait_load = 1'b1;
          wait_val  = WAIT_W'(POLL_GAP);
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      remain_q          <= '0;
      kick_q            <= 1'b0;
      gap_q             <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
      write_q           <= 1'b0;
      address_q         <= '0;
      data_in_q         <= '0;
      write_control_q   <= 1'b0;
      read_control_q    <= 1'b0;
      address_control_q <= 1'b0;
      data_in_control_q <= '0;
`ifdef MCCP_LOADER_CHECKSUM_EN
      sum_q             <= '0;
`endif
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      remain_q          <= remain_d;
      kick_q            <= kick_d;
      gap_q             <= gap_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
      write_q           <= write_d;
      address_q         <= address_d;
      data_in_q         <= data_in_d;
      write_control_q   <= write_control_d;
      read_control_q    <= read_control_d;
      address_control_q <= address_control_d;
      data_in_control_q <= data_in_control_d;
`ifdef MCCP_LOADER_CHECKSUM_EN
      sum_q             <= sum_d;
`endif
    end
  end

  assign bus.cmd_ready       = (state_q == IDLE);
  assign bus.s_ready         = (state_q == STREAM);
  assign bus.address         = address_q;
  assign bus.data_in         = data_in_q;
  assign bus.write           = write_q;
  assign bus.address_control = address_control_q;
  assign bus.data_in_control = data_in_control_q;
  assign bus.write_control   = write_control_q;
  assign bus.read_control    = read_control_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.dbg_state       = state_q;

  // Only the done bit of the status word is meaningful.
  assign unused_status = ^bus.data_out_control[WIDTH-1:1];

`ifdef MCCP_LOADER_CHECKSUM_EN
  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mccp_program_loader.sv
// Bench for mccp_program_loader: command table, stream driver, write scoreboard and status-slave model.
module tb_mccp_program_loader;
  import mccp_loader_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 17;

  typedef struct {
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       len;
    logic                    kick;
    logic                    gap;
    int                      done_poll;
    logic [3:0][WIDTH-1:0]   words;
    int                      exp_wc;
    int                      exp_rc;
    logic                    exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MCCP_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  mccp_program_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mccp_program_loader #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .READ_LATENCY(1), .POLL_GAP(2), .TIMEOUT(4)
  ) dut (
    .clk              (clk),
    .reset_sink_reset (rst),
    .bus              (bus)
`ifdef MCCP_LOADER_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  // ---------------- clock / counters ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W+WIDTH-1:0] exp_q[$];
  logic [ADDR_W+WIDTH-1:0] exp_e;
  vec_t vecs[8];

  // monitor-owned running totals
  int wr_total = 0, wc_total = 0, rc_total = 0;
  int wr_bad = 0, ctrl_bad = 0, excl_bad = 0;
  int last_wr_cyc = 0;

  // stimulus-owned state read by the status model
  int rc_base = 0;
  int cur_done_poll = 0;
  logic [WIDTH-1:0] exp_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      wr_total++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        wr_bad++;
        $display("FAIL write: unexpected write addr %0h data %0h", bus.address, bus.data_in);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.address, bus.data_in} !== exp_e) begin
          wr_bad++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.address, bus.data_in, exp_e[ADDR_W+WIDTH-1:WIDTH], exp_e[WIDTH-1:0]);
        end
      end
    end
    if (bus.write_control === 1'b1) begin
      wc_total++;
      if (bus.address_control !== CTRL_START_ADDR || bus.data_in_control !== WIDTH'(CTRL_START_VAL)) begin
        ctrl_bad++;
        $display("FAIL kick: got addr_ctl %0h data %0h expected 0 / 1", bus.address_control, bus.data_in_control);
      end
    end
    if (bus.read_control === 1'b1) begin
      rc_total++;
      if (bus.address_control !== CTRL_STATUS_ADDR) begin
        ctrl_bad++;
        $display("FAIL poll: got addr_ctl %0h expected 1", bus.address_control);
      end
    end
    if (int'(bus.write) + int'(bus.write_control) + int'(bus.read_control) > 1) begin
      excl_bad++;
      $display("FAIL excl: write %0b write_control %0b read_control %0b", bus.write, bus.write_control, bus.read_control);
    end
  end

  // ---------------- status slave model (one-cycle read latency) ----------------
  always @(posedge clk) begin
    if (bus.read_control === 1'b1)
      bus.data_out_control <= WIDTH'((cur_done_poll != 0) && ((rc_total - rc_base) >= cur_done_poll));
    else
      bus.data_out_control <= '0;
  end

  // ---------------- driver tasks ----------------
  task automatic set_vec(input int i, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                         input logic k, input logic g, input int dp,
                         input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                         input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3,
                         input int wc, input int rc, input logic er);
    vecs[i].addr = a;  vecs[i].len = l;  vecs[i].kick = k;  vecs[i].gap = g;
    vecs[i].done_poll = dp;
    vecs[i].words[0] = w0; vecs[i].words[1] = w1; vecs[i].words[2] = w2; vecs[i].words[3] = w3;
    vecs[i].exp_wc = wc; vecs[i].exp_rc = rc; vecs[i].exp_err = er;
  endtask

  task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l, input logic k);
    int t;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_kick  = k;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    exp_sum = '0;
  endtask

  task automatic send_words(input vec_t v, input int n);
    int k, guard;
    logic tog;
    logic [ADDR_W-1:0] a;
    k = 0; guard = 0; tog = 1'b0; a = v.addr;
    while (k < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (v.gap && tog) begin
        bus.s_valid = 1'b0;
        tog = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = v.words[k];
        if (bus.s_ready === 1'b1) begin
          exp_q.push_back({a, v.words[k]});
          exp_sum = exp_sum + v.words[k];
          a = a + ADDR_W'(1);
          k++;
          tog = 1'b1;
        end
      end
    end
    if (k < n) begin
      n_checks++; n_errors++;
      $display("FAIL stream_stall: sent %0d words expected %0d", k, n);
    end
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    int wr0, wc0, ctrl0, excl0, bad0, done_cyc;
    logic got, err_at_done;
    v = vecs[idx];
    wr0 = wr_total; wc0 = wc_total; bad0 = wr_bad; ctrl0 = ctrl_bad; excl0 = excl_bad;
    rc_base = rc_total;
    cur_done_poll = v.done_poll;
    issue_cmd(v.addr, v.len, v.kick);
    @(negedge clk);
    check($sformatf("v%0d_busy", idx), {bus.busy, bus.cmd_ready}, 2'b10);
    send_words(v, int'(v.len));
    if (v.len != 0) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
    got = 1'b0; err_at_done = 1'b0; done_cyc = 0;
    for (int t = 0; t < 300; t++) begin
      if (bus.done === 1'b1) begin
        got = 1'b1; err_at_done = bus.error; done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    #1;
    check($sformatf("v%0d_done_seen", idx), got, 1);
    check($sformatf("v%0d_error", idx), err_at_done, v.exp_err);
    check($sformatf("v%0d_idle_at_done", idx), {bus.busy, bus.cmd_ready}, 2'b01);
    check($sformatf("v%0d_n_writes", idx), wr_total - wr0, v.len);
    check($sformatf("v%0d_n_kicks", idx), wc_total - wc0, v.exp_wc);
    check($sformatf("v%0d_n_polls", idx), rc_total - rc_base, v.exp_rc);
    check($sformatf("v%0d_write_data", idx), wr_bad - bad0, 0);
    check($sformatf("v%0d_ctrl_fields", idx), ctrl_bad - ctrl0, 0);
    check($sformatf("v%0d_exclusive", idx), excl_bad - excl0, 0);
    check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 0);
    if (v.len != 0 && !v.kick)
      check($sformatf("v%0d_done_latency", idx), done_cyc - last_wr_cyc, 1);
`ifdef MCCP_LOADER_CHECKSUM_EN
    check($sformatf("v%0d_checksum", idx), checksum, exp_sum);
`endif
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), bus.done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wr0, bad0;
    vec_t rv;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_kick = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;

    set_vec(0, ADDR_W'(PROG_BASE), 3, 0, 0, 0, 32'h214C62A4, 32'h8F500000, 32'h729C42C0, 0, 0, 0, 0);
    set_vec(1, 17'h00000, 4, 0, 1, 0, 32'd4, 32'd2, 32'd3, 32'd5, 0, 0, 0);
    set_vec(2, 17'h00100, 1, 1, 0, 3, $urandom, 0, 0, 0, 1, 3, 0);
    set_vec(3, 17'h00200, 2, 1, 1, 0, $urandom, $urandom, 0, 0, 1, 4, 1);
    set_vec(4, 17'h00300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_vec(5, 17'h1FFFF, 2, 0, 0, 0, $urandom, $urandom, 0, 0, 0, 0, 0);
    set_vec(6, 17'h00010, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    set_vec(7, 17'h00050, 3, 0, 0, 0, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_strobes", {bus.write, bus.write_control, bus.read_control}, 3'b000);
    check("rst_status", {bus.busy, bus.done, bus.error}, 3'b000);
    check("rst_ready", {bus.cmd_ready, bus.s_ready}, 2'b10);
    check("rst_address", bus.address, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_data_in_control", bus.data_in_control, 0);
    check("rst_state", bus.dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 4) check("error_sticky", bus.error, 1);
      run_vector(i);
    end

    // reset after 2 of 5 words: transfer abandoned, nothing further issued
    cur_done_poll = 0;
    rv = vecs[7];
    rv.addr = 17'h00040;
    rv.words[0] = $urandom; rv.words[1] = $urandom;
    wr0 = wr_total; bad0 = wr_bad;
    issue_cmd(rv.addr, 5, 1'b0);
    send_words(rv, 2);
    @(negedge clk);
    #1;
    check("mid_writes_before_rst", wr_total - wr0, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_strobes", {bus.write, bus.write_control, bus.read_control}, 3'b000);
    check("mid_rst_ready", {bus.cmd_ready, bus.s_ready, bus.busy}, 3'b100);
    check("mid_rst_address", bus.address, 0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mid_no_more_writes", wr_total - wr0, 2);
    check("mid_write_data", wr_bad - bad0, 0);
    check("mid_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    run_vector(7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/mccp_program_loader.md
Name: mccp_program_loader

Overview:
- Host-side master that feeds the videocard_top data and control slaves.
- Takes a command (base address, word count, kick flag) plus a valid/ready word stream from the HPS bridge.
- Writes the words into consecutive videocard addresses (program region at 65536+, data region at 0+).
- Optionally writes 1 to control address 0 to start the MCCP, then polls control address 1 until the done bit sets or a timeout expires.

Parameters:
- WIDTH, 32, data word width
- ADDR_W, 17, videocard address width (WIDTH/2+1)
- READ_LATENCY, 1, cycles from ctrl_read to valid ctrl_rdata
- POLL_GAP, 8, idle cycles between successive status polls
- TIMEOUT, 4096, maximum number of polls before error

Ports:
- clk  in  1  system clock
- reset_sink_reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader idle, accepts command
- cmd_addr  in  ADDR_W  first destination address
- cmd_len  in  ADDR_W  word count; 0 is legal
- cmd_kick  in  1  start MCCP after load
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  WIDTH  stream word
- address  out  ADDR_W  videocard data address
- data_in  out  WIDTH  videocard write data
- write  out  1  videocard write strobe
- address_control  out  1  control register select
- data_in_control  out  WIDTH  control write data
- write_control  out  1  control write strobe
- read_control  out  1  control read strobe
- data_out_control  in  WIDTH  control read data; bit0 = done
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag; cleared by next accepted command

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All strobes, busy, done and error are 0; address, data_in and data_in_control are 0; cmd_ready = 1; s_ready = 0. Reset mid-transfer abandons the transfer; no further strobes are issued.
- IDLE: cmd_ready = 1.
  - On cmd_valid, latch addr, len and kick; clear error; busy goes to 1 on the next cycle.
  - If len = 0, go to KICK if kick is set, otherwise DONE.
  - Otherwise go to STREAM.
- STREAM: s_ready = 1. Each s_valid&&s_ready handshake produces, on the next edge, write = 1 for exactly one cycle with address = current and data_in = s_data.
  - Address increments by 1 per word and wraps modulo 2^ADDR_W.
  - Throughput is 1 word/cycle; the slave has no waitrequest.
  - After the len-th word: go to KICK if kick is set, otherwise DONE.
  - Stalls on s_valid = 0 are unbounded; no timeout applies in STREAM.
- KICK: one cycle with write_control = 1, address_control = 0, data_in_control = 1, then go to POLL_REQ.
- POLL_REQ: one cycle with read_control = 1 and address_control = 1, then go to POLL_WAIT.
- POLL_WAIT: wait READ_LATENCY cycles, then sample data_out_control[0].
  - If 1: go to DONE.
  - Else, if the poll count reaches TIMEOUT: set error and go to DONE.
  - Else: wait POLL_GAP cycles and return to POLL_REQ.
- DONE: done = 1 for one cycle, busy drops, return to IDLE.
- Mutual exclusion: write, write_control and read_control are never high together.
- cmd_valid while busy is ignored, because cmd_ready = 0.

Optional Feature:
- MCCP_LOADER_CHECKSUM_EN defined: adds output checksum[WIDTH-1:0]. It is the 32-bit wrap-around sum of all words written by the current command, cleared on command accept, and stable from done until the next accept.
- Undefined: no checksum port and no adder.

Decomposition:
- Package mccp_loader_pkg:
  - state enum: IDLE, STREAM, KICK, POLL_REQ, POLL_WAIT, DONE
  - CTRL_START_ADDR = 0, CTRL_STATUS_ADDR = 1, CTRL_START_VAL = 1
  - PROG_BASE = 65536
- Sub-module mccp_poll_timer: loadable down-counter handling both the READ_LATENCY/POLL_GAP waits and the TIMEOUT poll count; provides an expire strobe.

Test Plan:
- cmd addr = 65536, len = 3, kick = 0, words 0x214C62A4, 0x8F500000, 0x729C42C0 streamed back-to-back -> three consecutive write pulses at 65536..65538 carrying those words; done 1 cycle after the last write; no control strobes.
- cmd addr = 0, len = 4, s_valid toggling every other cycle, data 4, 2, 3, 5 -> writes at 0..3 with correct data, exactly four write pulses.
- kick = 1, len = 1; bench model sets done bit on the 3rd poll -> one write_control (address_control = 0, data = 1), exactly 3 read_control pulses, done pulse, error = 0.
- kick = 1, status never set, TIMEOUT = 4 -> 4 polls, error = 1, done pulse; next command clears error.
- len = 0, kick = 0 -> done pulse with no strobes. cmd addr = 0x1FFFF, len = 2 -> writes at 0x1FFFF then 0x00000.
- Reset asserted mid-STREAM after 2 of 5 words -> all strobes 0 immediately, cmd_ready = 1; with MCCP_LOADER_CHECKSUM_EN, the words 1, 2, 3 then give checksum = 6.
